rr_mux_arbiter: RTL
===================

# rr_mux_arbiter

Round-robin arbiter and sequencer for a shared 32-bit, 4-input data path. Four requesters present packets as 32-bit beats on one 128-bit concatenated bus. The block grants one requester at a time for a whole packet and drives the 2-bit slice select. Selected beats are registered onto a single valid/ready output channel toward the downstream consumer.

## Interface
- `WIDTH`, 32: beat width; per-requester slice of `In`.
- `MAX_BURST`, 8: max beats per grant before forced release; legal range 1..255.
- `Clk` input 1: single clock, rising edge.
- `Resetn` input 1: asynchronous, active-low reset.
- `Req` input 4: requester i has a valid beat on its slice.
- `Last` input 4: beat from requester i is the final beat of its packet.
- `In` input 4*WIDTH: requester i data at `[WIDTH*i+WIDTH-1 : WIDTH*i]`.
- `Gnt` output 4: one-hot ready to requester i; a beat transfers when `Req[i] & Gnt[i]`.
- `Sel` output 2: index of the current owner; also the slice select.
- `Out_Data` output WIDTH: registered beat.
- `Out_Valid` output 1: `Out_Data` holds an unconsumed beat.
- `Out_Last` output 1: registered copy of `Last[Sel]` for the beat.
- `Out_Src` output 2: requester index of the beat in `Out_Data`.
- `Out_Ready` input 1: consumer accepts the output beat when `Out_Valid & Out_Ready`.

## Operation
- Reset values: state IDLE, `Ptr`=0, `Sel`=0, `Beat_Cnt`=0, `Gnt`=0, `Out_Valid`=0, `Out_Data`=0, `Out_Last`=0, `Out_Src`=0.
- The FSM has two states, IDLE and GRANT.
- IDLE: `Gnt`=0. If `Req`≠0, pick the first set bit scanning `Ptr`, `Ptr+1`, ... mod 4. Then set `Sel`=winner, clear `Beat_Cnt`, and go to GRANT.
- GRANT: `Gnt[Sel]` = `!Out_Valid | Out_Ready`. All other `Gnt` bits are 0.
- On a transfer: `Out_Data` ← `In` slice `Sel`, `Out_Last` ← `Last[Sel]`, `Out_Src` ← `Sel`, `Out_Valid` ← 1, and `Beat_Cnt` increments.
- Release to IDLE with `Ptr` ← `Sel+1` (mod 4, wrap 3→0) when any of these holds:
  - the transfer has `Last[Sel]`=1;
  - the transfer has `Beat_Cnt`=`MAX_BURST-1` (forced release; `Out_Last` still mirrors `Last` only);
  - `Req[Sel]`=0 in GRANT (abandoned packet).
- `Out_Valid` clears when `Out_Ready` is high and no new transfer occurs in the same cycle. When a consume and a load coincide, the load wins and `Out_Valid` stays 1.
- Requests arriving while in GRANT are ignored until the next IDLE. The `Req` of the current owner is sampled only via `Req[Sel]`.
- `Sel` holds its value through IDLE until the next grant.
- An asynchronous reset mid-packet returns everything to reset values immediately. Any in-flight `Out_Data` beat is discarded.

## Timing
- `Req` seen in IDLE at cycle 0 → `Gnt` high in cycle 1 → `Out_Valid` high in cycle 2.
- Within a packet, throughput is 1 beat/cycle while `Out_Ready`=1.
- Exactly one IDLE cycle (bubble) separates consecutive grants.
- `Gnt` is combinational from state, `Out_Valid` and `Out_Ready`. No combinational path runs from `Req`/`In` to any output.
- The output register acts as a one-entry pipeline stage. `Out_Ready` low for k cycles stalls `Gnt` for those cycles, and no beat is lost or duplicated.

## Structure
- Shared header `rr_arb_defs.vh` contains:
  - `N_REQ`=4 and `SEL_W`=2;
  - state encodings `ST_IDLE`=1'b0 and `ST_GRANT`=1'b1.
- Sub-module `rr_pick4`: combinational round-robin picker. Inputs are `Req[3:0]` and `Ptr[1:0]`; outputs are `Winner[1:0]` and `Any`.
- Data selection is a 4:1 slice select on `In` driven by `Sel`.
- FSM, counter and output register live in the top module.

## Test plan
- Reset: `Resetn`=0 with random `Req`/`In` → all outputs 0. After release with `Req`=0 → `Gnt` stays 0.
- Single packet: `Req`=4'b0100, 3 beats 0xA0/0xA1/0xA2 with `Last` on the third, `Out_Ready`=1:
  - `Gnt`=4'b0100 on cycles 1–3;
  - `Out_Data` sequence 0xA0, 0xA1, 0xA2, with `Out_Src`=2;
  - `Out_Last` high on 0xA2 only;
  - `Ptr`=3 afterwards.
- Round-robin fairness: `Req`=4'b1111, every packet 1 beat with `Last`=1 → grant order 0, 1, 2, 3, 0, with one IDLE cycle between grants.
- Backpressure: single-beat-per-cycle packet from requester 1 with `Out_Ready`=0 for 3 cycles mid-packet → `Gnt[1]` low while `Out_Valid`=1 and `Out_Ready`=0. Every beat is emitted once, in order.
- Forced release: `MAX_BURST`=4, requester 0 sends 10 beats with `Last`=0 and requester 3 also requesting → after beat 4 the grant moves to 3, then returns to 0 for the remaining beats.
- Abandon and async reset: the owner drops `Req` mid-packet → IDLE next cycle and `Ptr`=owner+1. `Resetn` asserted while `Out_Valid`=1 → `Out_Valid`=0 in the same cycle, without waiting for `Clk`.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin 4-input mux arbiter.
// Holds requester count, select width, counter width, FSM state encoding
// and a small index helper used by the top module.
package rr_mux_arbiter_pkg;

    // Number of requesters sharing the data path and width of an index into them.
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    // Beat counter width: large enough for MAX_BURST up to 255.
    localparam int CNT_W = 8;

    // Two-state arbiter FSM.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Next requester index after idx. The natural 2-bit wrap gives 3 -> 0.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick4.sv
// Combinational round-robin picker for four requesters.
// Scans Req starting at Ptr, then Ptr+1, ... (mod 4) and reports the first
// set bit as Winner. Any flags that at least one request is present.
module rr_pick4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] Req,
    input  logic [SEL_W-1:0] Ptr,
    output logic [SEL_W-1:0] Winner,
    output logic             Any
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset back to Ptr so the closest set bit is assigned last and wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that leaves it unassigned infers a latch.
        Winner = Ptr;
        idx    = Ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = Ptr + SEL_W'(k);
            if (Req[idx]) begin
                Winner = idx;
            end
        end
    end

    assign Any = |Req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4-input data path.
// One requester owns the path for a whole packet (or until MAX_BURST beats,
// or until it drops its request). Granted beats are captured into a
// one-entry output register that drives a valid/ready channel.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ-1:0]       Last,
    input  logic [N_REQ*WIDTH-1:0] In,
    output logic [N_REQ-1:0]       Gnt,
    output logic [SEL_W-1:0]       Sel,
    output logic [WIDTH-1:0]       Out_Data,
    output logic                   Out_Valid,
    output logic                   Out_Last,
    output logic [SEL_W-1:0]       Out_Src,
    input  logic                   Out_Ready
);

    // Beat count at which the owner is forced to release the path.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic [SEL_W-1:0] winner;
    logic             any_req;

    logic             owner_req;
    logic             owner_last;
    logic [WIDTH-1:0] beat_data;
    logic             can_load;
    logic             xfer;
    logic             burst_end;
    logic             release_now;

    // Round-robin choice among current requests; only consumed while IDLE.
    rr_pick4 u_pick (
        .Req    (Req),
        .Ptr    (ptr),
        .Winner (winner),
        .Any    (any_req)
    );

    // The owner's request, last flag and data are only ever seen through Sel.
    assign owner_req  = Req[Sel];
    assign owner_last = Last[Sel];

    // 4:1 slice select of the requester data bus driven by Sel.
    always_comb begin
        beat_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (Sel == SEL_W'(i)) begin
                beat_data = In[i*WIDTH +: WIDTH];
            end
        end
    end

    // The output register can take a beat when empty or being drained this cycle.
    assign can_load  = !Out_Valid || Out_Ready;
    assign xfer      = (state == ST_GRANT) && owner_req && can_load;
    assign burst_end = (beat_cnt == BURST_LAST);

    // Release on the packet's last beat, on the burst limit, or when the owner abandons.
    assign release_now = (state == ST_GRANT) &&
                         (!owner_req || (xfer && (owner_last || burst_end)));

    // Next-state logic and the grant vector; Gnt depends only on state, Sel and the output handshake.
    always_comb begin
        state_next = state;
        Gnt        = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                Gnt[Sel] = can_load;
                if (release_now) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Owner select, round-robin pointer and beat counter. Sel holds through IDLE.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Sel      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == ST_IDLE && any_req) begin
                Sel      <= winner;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (release_now) begin
                ptr <= next_idx(Sel);
            end
        end
    end

    // One-entry output stage: a new beat wins over a same-cycle consume.
    always_ff @(posedge Clk or negedge Resetn) begin
        // NOTE: the data register is reset too, so a beat in flight is discarded and the bus reads 0 after reset.
        if (!Resetn) begin
            Out_Data  <= '0;
            Out_Last  <= 1'b0;
            Out_Src   <= '0;
            Out_Valid <= 1'b0;
        end else if (xfer) begin
            Out_Data  <= beat_data;
            Out_Last  <= owner_last;
            Out_Src   <= Sel;
            Out_Valid <= 1'b1;
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

endmodule
